// File: rtl/ram32_port_arbiter.sv
// Front-end controller for the 32x32 dual-port RAM macro: post-reset zero-fill,
// round-robin A/B arbitration onto R/W port 0, read-only requester R on port 1.
module ram32_port_arbiter #(
  parameter int unsigned ADDR_W        = 5,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              init_done,

  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [3:0]        a_req_we,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,

  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [3:0]        b_req_we,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,

  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_rsp_valid,
  output logic [DATA_W-1:0] r_rsp_rdata,

  output logic              ram_en0,
  output logic [ADDR_W-1:0] ram_a0,
  output logic [3:0]        ram_we0,
  output logic [DATA_W-1:0] ram_di0,
  input  logic [DATA_W-1:0] ram_do0,
  output logic              ram_en1,
  output logic [ADDR_W-1:0] ram_a1,
  input  logic [DATA_W-1:0] ram_do1
);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              prio_b_q, prio_b_d;
  logic              grant_a, grant_b, r_fire;

  // Next state, arbitration and macro drive
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_b_d    = prio_b_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    r_fire      = 1'b0;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    r_req_ready = 1'b0;
    ram_en0     = 1'b0;
    ram_a0      = '0;
    ram_we0     = '0;
    ram_di0     = '0;
    ram_en1     = 1'b0;
    ram_a1      = '0;
    unique case (state_q)
      IDLE: state_d = (INIT_ON_RESET != 0) ? INIT : RUN;
      INIT: begin
        ram_en0 = 1'b1;
        ram_we0 = 4'hF;
        ram_a0  = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        r_req_ready = 1'b1;
        r_fire      = r_req_valid;
        grant_a     = a_req_valid && (!b_req_valid || !prio_b_q);
        grant_b     = b_req_valid && (!a_req_valid ||  prio_b_q);
        a_req_ready = grant_a;
        b_req_ready = grant_b;
        if (grant_a) begin
          prio_b_d = 1'b1;
          ram_a0   = a_req_addr;
          ram_we0  = a_req_we;
          ram_di0  = a_req_wdata;
        end else if (grant_b) begin
          prio_b_d = 1'b0;
          ram_a0   = b_req_addr;
          ram_we0  = b_req_we;
          ram_di0  = b_req_wdata;
        end
        // Port 0 must be enabled on R cycles too: the macro only refreshes Do1 on EN0.
        ram_en0 = grant_a || grant_b || r_fire;
        ram_en1 = r_fire;
        if (r_fire) ram_a1 = r_req_addr;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prio_b_q    <= 1'b0;
      init_done   <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_b_q    <= prio_b_d;
      init_done   <= (state_d == RUN);
      a_rsp_valid <= grant_a;
      b_rsp_valid <= grant_b;
      r_rsp_valid <= r_fire;
    end
  end

  // Read data comes straight from the macro's latched outputs
  assign a_rsp_rdata = ram_do0;
  assign b_rsp_rdata = ram_do0;
  assign r_rsp_rdata = ram_do1;

endmodule
